// File: rtl/result_packer_pkg.sv
// Shared definitions for the result packer: config register map and FSM states.
package result_packer_pkg;

    localparam int CFG_PACKER = 4;

    localparam int CNT_LSB   = 0;
    localparam int CNT_MSB   = 15;
    localparam int BEATS_LSB = 16;
    localparam int BEATS_MSB = 19;

    typedef enum logic {
        IDLE,
        SEND
    } pk_state_e;

endpackage

// File: rtl/result_packer.sv
// Serialises DEPTH_NB-lane result vectors into STR_WIDTH beats and marks
// the final beat of each layer with str_last.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int DEPTH_NB   = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int STR_WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [STR_WIDTH-1:0]          str_bus,
    output logic                          str_last,
    output logic                          str_val,
    input  logic                          str_rdy
);

    localparam int VEC_W = IMG_WIDTH * DEPTH_NB;
    localparam int RATIO = VEC_W / STR_WIDTH;
    localparam int BCW   = $clog2(RATIO + 1);
    localparam int RCW   = CNT_MSB - CNT_LSB + 1;
    localparam int BFW   = BEATS_MSB - BEATS_LSB + 1;

    pk_state_e        state_q, state_d;
    logic [VEC_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [RCW-1:0]   res_cnt_q, res_cnt_d;
    logic             str_last_q, str_last_d;
    logic [RCW-1:0]   sh_count_q, sh_count_d;
    logic [BCW-1:0]   sh_beats_q, sh_beats_d;
    logic [RCW-1:0]   act_count_q, act_count_d;
    logic [BCW-1:0]   act_beats_q, act_beats_d;

    logic [RCW-1:0] cfg_cnt;
    logic [BFW-1:0] cfg_bts;
    logic [RCW-1:0] eff_count;
    logic [BCW-1:0] eff_beats;
    logic           fin_beat;
    logic           last_res;
    logic           adv;
    logic           accept;

    assign cfg_cnt  = cfg_data[CNT_MSB:CNT_LSB];
    assign cfg_bts  = cfg_data[BEATS_MSB:BEATS_LSB];
    assign fin_beat = (state_q == SEND) && (beat_cnt_q == act_beats_q - BCW'(1));
    assign last_res = (res_cnt_q == act_count_q - RCW'(1));
    assign adv      = (state_q == SEND) && str_rdy;

    assign result_rdy = rst && ((state_q == IDLE) || (fin_beat && str_rdy));
    assign accept     = result_val && result_rdy;

    assign str_val  = (state_q == SEND);
    assign str_bus  = shreg_q[STR_WIDTH-1:0];
    assign str_last = str_last_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        beat_cnt_d  = beat_cnt_q;
        res_cnt_d   = res_cnt_q;
        str_last_d  = str_last_q;
        sh_count_d  = sh_count_q;
        sh_beats_d  = sh_beats_q;
        act_count_d = act_count_q;
        act_beats_d = act_beats_q;
        eff_count   = act_count_q;
        eff_beats   = act_beats_q;

        if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_PACKER)) begin
            sh_count_d = (cfg_cnt == '0) ? RCW'(1) : cfg_cnt;
            sh_beats_d = (cfg_bts == '0 || int'(cfg_bts) > RATIO) ?
                         BCW'(RATIO) : BCW'(cfg_bts);
        end

        if (adv && fin_beat)
            res_cnt_d = last_res ? '0 : res_cnt_q + RCW'(1);

        // A vector entering at result index 0 opens a new layer.
        if (accept && res_cnt_d == '0) begin
            act_count_d = sh_count_q;
            act_beats_d = sh_beats_q;
            eff_count   = sh_count_q;
            eff_beats   = sh_beats_q;
        end

        if (accept) begin
            state_d    = SEND;
            shreg_d    = result_bus;
            beat_cnt_d = '0;
            str_last_d = (eff_beats == BCW'(1)) &&
                         (res_cnt_d == eff_count - RCW'(1));
        end else if (adv && fin_beat) begin
            state_d    = IDLE;
            str_last_d = 1'b0;
        end else if (adv) begin
            shreg_d    = shreg_q >> STR_WIDTH;
            beat_cnt_d = beat_cnt_q + BCW'(1);
            str_last_d = (beat_cnt_q + BCW'(1) == act_beats_q - BCW'(1)) &&
                         last_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            str_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            str_last_q <= str_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            res_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_count_q  <= RCW'(1);
            sh_beats_q  <= BCW'(RATIO);
            act_count_q <= RCW'(1);
            act_beats_q <= BCW'(RATIO);
        end else begin
            sh_count_q  <= sh_count_d;
            sh_beats_q  <= sh_beats_d;
            act_count_q <= act_count_d;
            act_beats_q <= act_beats_d;
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: table of layer scenarios plus a
// hand-written mid-layer reset sequence.
module tb_result_packer;
    import result_packer_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cfg_data;
    logic [4:0]   cfg_addr;
    logic         cfg_valid;
    logic [255:0] result_bus;
    logic         result_val;
    logic         result_rdy;
    logic [63:0]  str_bus;
    logic         str_last;
    logic         str_val;
    logic         str_rdy;

    int n_vec = 0;
    int n_err = 0;

    result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .result_bus (result_bus),
        .result_val (result_val),
        .result_rdy (result_rdy),
        .str_bus    (str_bus),
        .str_last   (str_last),
        .str_val    (str_val),
        .str_rdy    (str_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pre_en;
        logic [31:0] pre_cfg;
        int          mid_vec;
        logic [31:0] mid_cfg;
        int          nvec;
        logic        tog;
        int          beats;
        int          last_mask;
    } entry_t;

    entry_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_vec(input int v);
        logic [255:0] r;
        for (int i = 0; i < 16; i++)
            r[16*i +: 16] = {8'(v), 8'(i)};
        return r;
    endfunction

    function automatic logic [63:0] exp_beat(input int v, input int b);
        logic [63:0] r;
        for (int j = 0; j < 4; j++)
            r[16*j +: 16] = {8'(v), 8'(4*b + j)};
        return r;
    endfunction

    task automatic cfg_write(input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = 5'(CFG_PACKER);
        cfg_data  = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_entry(input entry_t e);
        int   sent = 0;
        int   kv = 0;
        int   kb = 0;
        int   cyc = 0;
        int   firstc = -1;
        int   lastc = 0;
        logic pend = 1'b0;
        logic mid_done = 1'b0;
        logic [63:0] hold_bus = '0;
        logic hold_last = 1'b0;
        int   span;
        if (e.pre_en) cfg_write(e.pre_cfg);
        while (kv < e.nvec && cyc < 300) begin
            str_rdy    = e.tog ? (cyc % 2 == 1) : 1'b1;
            result_val = (sent < e.nvec);
            result_bus = mk_vec(sent);
            cfg_valid  = 1'b0;
            if (e.mid_vec >= 0 && sent == e.mid_vec && !mid_done) begin
                cfg_valid = 1'b1;
                cfg_addr  = 5'(CFG_PACKER);
                cfg_data  = e.mid_cfg;
                mid_done  = 1'b1;
            end
            #1;
            if (pend) begin
                chk({e.name, " stall_val"}, 64'(str_val), 64'd1);
                chk({e.name, " stall_bus"}, str_bus, hold_bus);
                chk({e.name, " stall_last"}, 64'(str_last), 64'(hold_last));
            end
            pend = 1'b0;
            if (str_val) begin
                if (str_rdy) begin
                    if (firstc < 0) firstc = cyc;
                    lastc = cyc;
                    chk($sformatf("%s v%0d b%0d bus", e.name, kv, kb),
                        str_bus, exp_beat(kv, kb));
                    chk($sformatf("%s v%0d b%0d last", e.name, kv, kb),
                        64'(str_last),
                        64'((kb == e.beats - 1) && ((e.last_mask >> kv) & 1) == 1));
                    kb++;
                    if (kb == e.beats) begin
                        kb = 0;
                        kv++;
                    end
                end else begin
                    pend      = 1'b1;
                    hold_bus  = str_bus;
                    hold_last = str_last;
                end
            end
            if (result_val && result_rdy) sent++;
            @(negedge clk);
            cyc++;
        end
        result_val = 1'b0;
        cfg_valid  = 1'b0;
        str_rdy    = 1'b1;
        if (kv < e.nvec) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got %0d vectors required %0d",
                     e.name, kv, e.nvec);
        end else begin
            span = e.tog ? 2 * e.nvec * e.beats - 1 : e.nvec * e.beats;
            chk({e.name, " latency"}, 64'(firstc), 64'd1);
            chk({e.name, " span"}, 64'(lastc - firstc + 1), 64'(span));
        end
        @(negedge clk);
    endtask

    initial begin
        entry_t post;
        int nb;
        int sent;

        tbl[0] = '{"two_vec",  1'b1, 32'h0000_0002, -1, 32'h0, 2, 1'b0, 4, 'b10};
        tbl[1] = '{"toggle",   1'b1, 32'h0000_0002, -1, 32'h0, 4, 1'b1, 4, 'b1010};
        tbl[2] = '{"beats2",   1'b1, 32'h0002_0003, -1, 32'h0, 3, 1'b0, 2, 'b100};
        tbl[3] = '{"mid_cfg",  1'b1, 32'h0000_0002,  1, 32'h0000_0005, 7, 1'b0, 4, 'h42};
        tbl[4] = '{"beats_ov", 1'b1, 32'h0009_0001, -1, 32'h0, 1, 1'b0, 4, 'b1};
        tbl[5] = '{"beats1",   1'b1, 32'h0001_0001, -1, 32'h0, 2, 1'b1, 1, 'b11};
        tbl[6] = '{"count0",   1'b1, 32'h0000_0000, -1, 32'h0, 2, 1'b0, 4, 'b11};

        rst        = 1'b0;
        cfg_data   = '0;
        cfg_addr   = '0;
        cfg_valid  = 1'b0;
        result_bus = '0;
        result_val = 1'b0;
        str_rdy    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst str_val", 64'(str_val), 64'd0);
        chk("rst str_last", 64'(str_last), 64'd0);
        chk("rst str_bus", str_bus, 64'd0);
        chk("rst result_rdy", 64'(result_rdy), 64'd0);
        @(negedge clk);
        rst     = 1'b1;
        str_rdy = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_entry(tbl[i]);

        // Reset arrives while the second beat of the layer's final vector is held.
        cfg_write(32'h0000_0002);
        nb   = 0;
        sent = 0;
        for (int c = 0; c < 40 && nb < 5; c++) begin
            str_rdy    = 1'b1;
            result_val = (sent < 2);
            result_bus = mk_vec(sent);
            #1;
            if (str_val) nb++;
            if (result_val && result_rdy) sent++;
            @(negedge clk);
        end
        chk("pre_rst beats", 64'(nb), 64'd5);
        #1;
        chk("pre_rst last", 64'(str_last), 64'd0);
        rst        = 1'b0;
        result_val = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst str_val", 64'(str_val), 64'd0);
        chk("mid_rst str_last", 64'(str_last), 64'd0);
        chk("mid_rst str_bus", str_bus, 64'd0);
        chk("mid_rst result_rdy", 64'(result_rdy), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        post = '{"post_rst", 1'b0, 32'h0, -1, 32'h0, 1, 1'b0, 4, 'b1};
        run_entry(post);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
